// File: rtl/matrix_mult_nxn.sv
// Signed fixed-point NxN matrix multiplier (C = A x B) built on one sequential MAC.
// Operands load element-wise in IDLE; results stream out row-major over valid/ready.
module matrix_mult_nxn #(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int FRAC = 16,
  parameter int AW   = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          sat,
  output logic          done
);

  localparam int NN   = N * N;
  localparam int CW   = $clog2(N);
  localparam int PW   = 2 * DW;
  localparam int ACCW = PW + $clog2(N);
  localparam int RW   = ACCW + 1;

  localparam logic [CW-1:0]        LAST    = CW'(N - 1);
  localparam logic [RW-1:0]        RND     = (RW'(1) << FRAC) >> 1;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] a_mem [NN];
  logic [DW-1:0] b_mem [NN];
  logic [DW-1:0] c_mem [NN];

  logic [CW-1:0]          i_q, j_q, k_q;
  logic signed [ACCW-1:0] acc;
  logic                   sat_q;

  logic [DW-1:0]          a_op, b_op;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [RW-1:0]   round_sum, rounded;
  logic [DW-1:0]          wb_data;
  logic                   wb_clip;
  logic                   idle_write, mac_last, elem_last, fire;

  function automatic logic [AW-1:0] flat(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(N) + AW'(c);
  endfunction

  assign idle_write = rst_n && (state == S_IDLE) && wr_en && ({1'b0, wr_addr} < (AW+1)'(NN));
  assign mac_last   = (k_q == LAST);
  assign elem_last  = (i_q == LAST) && (j_q == LAST);
  assign fire       = (state == S_DRAIN) && out_ready;

  // Full-precision signed product; operands are sign-extended so the low PW bits are exact.
  assign a_op      = a_mem[flat(i_q, k_q)];
  assign b_op      = b_mem[flat(k_q, j_q)];
  assign prod      = $signed({{DW{a_op[DW-1]}}, a_op}) * $signed({{DW{b_op[DW-1]}}, b_op});
  assign prod_ext  = {{(ACCW-PW){prod[PW-1]}}, prod};
  assign round_sum = {acc[ACCW-1], acc} + RND;
  assign rounded   = round_sum >>> FRAC;

  // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    wb_data = rounded[DW-1:0];
    wb_clip = 1'b0;
    if (rounded > SAT_MAX) begin
      wb_data = {1'b0, {(DW-1){1'b1}}};
      wb_clip = 1'b1;
    end else if (rounded < SAT_MIN) begin
      wb_data = {1'b1, {(DW-1){1'b0}}};
      wb_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_MAC;
      S_MAC:   if (mac_last) state_nxt = S_WB;
      S_WB:    state_nxt = elem_last ? S_DRAIN : S_MAC;
      S_DRAIN: if (fire && elem_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_MAC) || (state == S_WB) || (state == S_DRAIN);
    out_valid = (state == S_DRAIN);
    out_last  = (state == S_DRAIN) && elem_last;
    out_data  = (state == S_DRAIN) ? c_mem[flat(i_q, j_q)] : '0;
    done      = (state == S_DONE);
  end

  assign sat = sat_q;

  // WB walks (i,j) toward the next element; after the last one both wrap to 0 ready for DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      acc   <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          i_q   <= '0;
          j_q   <= '0;
          k_q   <= '0;
          sat_q <= 1'b0;
        end
        S_MAC: begin
          acc <= (k_q == '0) ? prod_ext : acc + prod_ext;
          k_q <= mac_last ? '0 : k_q + 1'b1;
        end
        S_WB, S_DRAIN: if (state == S_WB || fire) begin
          if (state == S_WB) sat_q <= sat_q | wb_clip;
          if (j_q == LAST) begin
            j_q <= '0;
            i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand/result storage has no reset so it maps to plain RAM; A/B survive a reset.
  always_ff @(posedge clk) begin
    if (idle_write) begin
      if (wr_sel) b_mem[wr_addr] <= wr_data;
      else        a_mem[wr_addr] <= wr_data;
    end
    if (state == S_WB) c_mem[flat(i_q, j_q)] <= wb_data;
  end

endmodule
